ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Keystroke source for the typing-game checker. Receives raw PS/2 keyboard frames, decodes scan code set 2 break sequences for letters A–Z, and emits a 5-bit letter code `kstrk` with a one-cycle release strobe `kr`. Sits between the board PS/2 pins and the word checker's `kstrk`/`kr` inputs.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchronizer for `ps2_clk` and `ps2_data`.
- FILTER_LEN, 8, consecutive equal `ps2_clk` samples required before the filtered level changes.
- TIMEOUT_CYC, 100000, clk cycles with no filtered falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
- ps2_data  in  1  raw PS/2 data pin (asynchronous)
- kstrk  out  5  letter code of the last released letter key; 1=A … 26=Z
- kr  out  1  one-cycle strobe: a letter key was released
- frame_err  out  1  one-cycle strobe: parity error, stop error or timeout

Behaviour:
- Reset: `kstrk`=0, `kr`=0, `frame_err`=0. Synchronizers and filter preset to 1 (bus idle). Frame FSM goes to IDLE, code FSM to NORMAL, bit and timeout counters to 0. Reset has priority over every other event.
- Reset asserted mid-frame discards the partial frame; no `kr` and no `frame_err` are produced for it.
- Pin path: SYNC_STAGES synchronizer, then the FILTER_LEN glitch filter. A sample event is a 1→0 transition of the filtered clock.
- Frame FSM (11-bit frame, one bit per sample event):
  - IDLE: start bit must be 0, otherwise ignore it and stay in IDLE.
  - DATA: 8 bits, LSB first.
  - PARITY: the 9 bits (data plus parity) must have odd parity.
  - STOP: must be 1.
  - Valid frame: internal `byte_rdy` pulses 1 cycle after the stop sample event, carrying the byte.
  - Parity or stop failure: `frame_err` pulses 1 cycle after the stop sample event, the byte is discarded, FSM returns to IDLE.
- Timeout:
  - The counter runs only while not in IDLE and clears on every sample event.
  - Reaching TIMEOUT_CYC returns the FSM to IDLE and pulses `frame_err` once.
- Code FSM (advances on `byte_rdy`):
  - NORMAL: E0→EXT; F0→BREAK; any other byte is a make code and is ignored.
  - EXT: F0→EXT_BREAK; any other byte→NORMAL.
  - BREAK: any byte→NORMAL. If the byte maps to a letter, set `kstrk` to the letter code and pulse `kr`. Non-letters produce no output.
  - EXT_BREAK: any byte→NORMAL, no output.
  - Any `frame_err` forces the code FSM to NORMAL.
- Letter map (scan code→letter):
  - 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M
  - 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z
  - All other codes map to 0 (no letter).
- Output timing:
  - `kr` is registered. It goes high exactly 2 clk cycles after the stop sample event of the released code's frame and stays high for 1 cycle.
  - `kstrk` updates in the same cycle `kr` rises and holds until the next `kr`.
  - Auto-repeat make codes never produce `kr`. Each release produces exactly one `kr`.
- `kr` and `frame_err` are never high in the same cycle.

Decomposition:
- Shared package `typing_pkg`:
  - `LET_NONE`=0 and `LET_A`…`LET_Z`=1…26 (the same encoding used by the word register and checker).
  - `SC_BREAK`=8'hF0, `SC_EXT`=8'hE0.
  - Function `scan_to_letter(byte)` returning 5 bits.
  - Code FSM state typedef.
- Sub-module `ps2_frame_rx`: synchronizer, filter, frame FSM and timeout. Outputs `byte[7:0]`, `byte_rdy` and `frame_err`.
- `ps2_key_decoder` instantiates `ps2_frame_rx` and holds the code FSM, letter map and output registers.

Test Plan (sim parameters FILTER_LEN=4, TIMEOUT_CYC=2000; PS/2 bit period 80 clk):
1. Frames 1C, F0, 1C → no `kr` after the make; exactly one `kr` after the final frame with `kstrk`=1, high for 1 cycle, 2 cycles after the stop sample.
2. Frames 1C, 1C, 1C (auto-repeat), then F0, 1A → single `kr`, `kstrk`=26; `kstrk` then holds 26 for the following 500 cycles.
3. Frames E0, F0, 1C, then F0, 12 (non-letter) → no `kr`, no `frame_err`; `kstrk` unchanged from the prior value.
4. Frame F0, then 1C with the parity bit flipped → one `frame_err` pulse, no `kr`. A following good 1C (make) → still no `kr`, because the FSM was forced to NORMAL.
5. Stop clocking after 5 bits of a frame for 2010 cycles → one `frame_err` at cycle 2000 after the last edge. Then frames F0, 2C → `kr` with `kstrk`=20. Separately, a 3-cycle low glitch on `ps2_clk` while idle → no bit sampled, no `frame_err`.
6. Assert `reset` for 1 cycle after the 4th bit of an F0 frame → all outputs 0, no strobes. Then frames F0, 24 → `kr` with `kstrk`=5.

Source files
------------

// File: rtl/typing_pkg.sv
//==============================================================================
// typing_pkg : letter encoding, PS/2 prefix codes and FSM state types shared
//              by the keystroke decoder and the word checker.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package typing_pkg;

  localparam logic [4:0] LET_NONE = 5'd0;
  localparam logic [4:0] LET_A = 5'd1;
  localparam logic [4:0] LET_B = 5'd2;
  localparam logic [4:0] LET_C = 5'd3;
  localparam logic [4:0] LET_D = 5'd4;
  localparam logic [4:0] LET_E = 5'd5;
  localparam logic [4:0] LET_F = 5'd6;
  localparam logic [4:0] LET_G = 5'd7;
  localparam logic [4:0] LET_H = 5'd8;
  localparam logic [4:0] LET_I = 5'd9;
  localparam logic [4:0] LET_J = 5'd10;
  localparam logic [4:0] LET_K = 5'd11;
  localparam logic [4:0] LET_L = 5'd12;
  localparam logic [4:0] LET_M = 5'd13;
  localparam logic [4:0] LET_N = 5'd14;
  localparam logic [4:0] LET_O = 5'd15;
  localparam logic [4:0] LET_P = 5'd16;
  localparam logic [4:0] LET_Q = 5'd17;
  localparam logic [4:0] LET_R = 5'd18;
  localparam logic [4:0] LET_S = 5'd19;
  localparam logic [4:0] LET_T = 5'd20;
  localparam logic [4:0] LET_U = 5'd21;
  localparam logic [4:0] LET_V = 5'd22;
  localparam logic [4:0] LET_W = 5'd23;
  localparam logic [4:0] LET_X = 5'd24;
  localparam logic [4:0] LET_Y = 5'd25;
  localparam logic [4:0] LET_Z = 5'd26;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    CS_NORMAL    = 2'd0,
    CS_EXT       = 2'd1,
    CS_BREAK     = 2'd2,
    CS_EXT_BREAK = 2'd3
  } code_state_t;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_DATA   = 2'd1,
    FS_PARITY = 2'd2,
    FS_STOP   = 2'd3
  } frame_state_t;

  // Scan code set 2 make codes of the letter keys.
  function automatic logic [4:0] scan_to_letter(input logic [7:0] code);
    logic [4:0] let_v;
    let_v = LET_NONE;
    case (code)
      8'h1C: let_v = LET_A;
      8'h32: let_v = LET_B;
      8'h21: let_v = LET_C;
      8'h23: let_v = LET_D;
      8'h24: let_v = LET_E;
      8'h2B: let_v = LET_F;
      8'h34: let_v = LET_G;
      8'h33: let_v = LET_H;
      8'h43: let_v = LET_I;
      8'h3B: let_v = LET_J;
      8'h42: let_v = LET_K;
      8'h4B: let_v = LET_L;
      8'h3A: let_v = LET_M;
      8'h31: let_v = LET_N;
      8'h44: let_v = LET_O;
      8'h4D: let_v = LET_P;
      8'h15: let_v = LET_Q;
      8'h2D: let_v = LET_R;
      8'h1B: let_v = LET_S;
      8'h2C: let_v = LET_T;
      8'h3C: let_v = LET_U;
      8'h2A: let_v = LET_V;
      8'h1D: let_v = LET_W;
      8'h22: let_v = LET_X;
      8'h35: let_v = LET_Y;
      8'h1A: let_v = LET_Z;
      default: let_v = LET_NONE;
    endcase
    return let_v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
//==============================================================================
// ps2_key_decoder_if : PS/2 pins in, letter keystroke and error strobes out.
// Revision           : 1.0
//==============================================================================
`default_nettype none

interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] kstrk;
  logic       kr;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  kstrk, kr, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output kstrk, kr, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder_frame_rx.sv
//==============================================================================
// ps2_frame_rx : pin synchronizers, clock glitch filter, 11-bit frame FSM and
//                partial-frame timeout. Emits one byte per valid frame.
// Revision     : 1.0
//==============================================================================
`default_nettype none

module ps2_frame_rx
  import typing_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_rdy_o,
  output logic       frame_err_o
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_s;
  logic                   data_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  logic           filt_q;
  logic [FCW-1:0] fcnt_q;
  logic           filt_flip;
  logic           sample_evt;

  // The filtered level follows only after FILTER_LEN consecutive differing samples.
  assign filt_flip  = (clk_s != filt_q) && (fcnt_q == FCW'(FILTER_LEN - 1));
  assign sample_evt = filt_flip && filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_s == filt_q) begin
      fcnt_q <= '0;
    end else if (filt_flip) begin
      filt_q <= clk_s;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FCW'(1);
    end
  end

  frame_state_t   state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           par_ok_q;
  logic [TCW-1:0] tcnt_q;
  logic           byte_rdy_q;
  logic           frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FS_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tcnt_q      <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (sample_evt) begin
        tcnt_q <= '0;
        case (state_q)
          FS_IDLE: begin
            if (!data_s) begin
              state_q   <= FS_DATA;
              bit_cnt_q <= '0;
            end
          end
          FS_DATA: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= FS_PARITY;
          end
          FS_PARITY: begin
            par_ok_q <= ^{data_s, shift_q};
            state_q  <= FS_STOP;
          end
          FS_STOP: begin
            state_q <= FS_IDLE;
            if (data_s && par_ok_q) byte_rdy_q  <= 1'b1;
            else                    frame_err_q <= 1'b1;
          end
          default: state_q <= FS_IDLE;
        endcase
      end else if (state_q != FS_IDLE) begin
        if (tcnt_q == TCW'(TIMEOUT_CYC - 1)) begin
          state_q     <= FS_IDLE;
          tcnt_q      <= '0;
          frame_err_q <= 1'b1;
        end else begin
          tcnt_q <= tcnt_q + TCW'(1);
        end
      end
    end
  end

  assign byte_o      = shift_q;
  assign byte_rdy_o  = byte_rdy_q;
  assign frame_err_o = frame_err_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
//==============================================================================
// ps2_key_decoder : turns PS/2 break sequences for letter keys into a letter
//                   code with a one-cycle release strobe.
// Revision        : 1.0
//==============================================================================
`default_nettype none

module ps2_key_decoder
  import typing_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_decoder_if.slave bus
);

  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic       rx_err;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (bus.ps2_clk),
    .ps2_data_i  (bus.ps2_data),
    .byte_o      (rx_byte),
    .byte_rdy_o  (rx_rdy),
    .frame_err_o (rx_err)
  );

  code_state_t cstate_q;
  logic [4:0]  kstrk_q;
  logic        kr_q;
  logic [4:0]  letter;

  assign letter = scan_to_letter(rx_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      cstate_q <= CS_NORMAL;
      kstrk_q  <= LET_NONE;
      kr_q     <= 1'b0;
    end else begin
      kr_q <= 1'b0;
      if (rx_err) begin
        cstate_q <= CS_NORMAL;
      end else if (rx_rdy) begin
        case (cstate_q)
          CS_NORMAL: begin
            if (rx_byte == SC_EXT)        cstate_q <= CS_EXT;
            else if (rx_byte == SC_BREAK) cstate_q <= CS_BREAK;
          end
          CS_EXT: begin
            cstate_q <= (rx_byte == SC_BREAK) ? CS_EXT_BREAK : CS_NORMAL;
          end
          CS_BREAK: begin
            cstate_q <= CS_NORMAL;
            if (letter != LET_NONE) begin
              kstrk_q <= letter;
              kr_q    <= 1'b1;
            end
          end
          default: cstate_q <= CS_NORMAL;
        endcase
      end
    end
  end

  assign bus.kstrk     = kstrk_q;
  assign bus.kr        = kr_q;
  assign bus.frame_err = rx_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
//==============================================================================
// tb_ps2_key_decoder : table-driven, hand-written and random keystroke events
//                      checked against an event-level keyboard model.
// Revision           : 1.0
//==============================================================================
`default_nettype none

module tb_ps2_key_decoder;

  localparam int SYNC     = 2;
  localparam int FLEN     = 4;
  localparam int TOUT     = 2000;
  localparam int HALF_BIT = 40;
  localparam int KR_LO    = SYNC + FLEN;
  localparam int KR_HI    = SYNC + FLEN + 3;
  localparam int ERR_LO   = SYNC + FLEN - 1;
  localparam int ERR_HI   = SYNC + FLEN + 2;

  typedef enum logic [2:0] {
    EV_MAKE, EV_REL, EV_EXT_MAKE, EV_EXT_REL, EV_BAD, EV_REL_BADPAR, EV_REL_BADSTOP
  } ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    logic [7:0] code;
    int         exp_kr;
    int         exp_ks;
    int         exp_err;
    int         hold;
  } vec_t;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .SYNC_STAGES (SYNC),
    .FILTER_LEN  (FLEN),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int kr_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_kr_cyc = 0, last_err_cyc = 0, last_fall_cyc = 0;

  always @(negedge clk) begin
    if (bus.kr === 1'b1) begin
      kr_cnt++;
      last_kr_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (bus.kr === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  logic [7:0] letter_sc [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  function automatic int ref_letter(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (letter_sc[i] == c) return i + 1;
    return 0;
  endfunction

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      repeat (HALF_BIT) @(negedge clk);
      bus.ps2_clk   = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF_BIT) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (HALF_BIT) @(negedge clk);
  endtask

  task automatic apply_event(input ev_kind_t k, input logic [7:0] code, input int exp_kr,
                             input int exp_ks, input int exp_err, input string nm);
    int kr0, e0;
    kr0 = kr_cnt;
    e0  = err_cnt;
    case (k)
      EV_MAKE:     send_frame(code, 1'b0, 1'b0, 11);
      EV_REL:      begin send_frame(8'hF0, 1'b0, 1'b0, 11); send_frame(code, 1'b0, 1'b0, 11); end
      EV_EXT_MAKE: begin send_frame(8'hE0, 1'b0, 1'b0, 11); send_frame(code, 1'b0, 1'b0, 11); end
      EV_EXT_REL: begin
        send_frame(8'hE0, 1'b0, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        send_frame(code, 1'b0, 1'b0, 11);
      end
      EV_BAD:         send_frame(code, 1'b1, 1'b0, 11);
      EV_REL_BADPAR:  begin send_frame(8'hF0, 1'b0, 1'b0, 11); send_frame(code, 1'b1, 1'b0, 11); end
      EV_REL_BADSTOP: begin send_frame(8'hF0, 1'b0, 1'b0, 11); send_frame(code, 1'b0, 1'b1, 11); end
      default:        send_frame(code, 1'b0, 1'b0, 11);
    endcase
    repeat (30) @(negedge clk);
    chk($sformatf("%s.kr_count", nm), kr_cnt - kr0, exp_kr);
    chk($sformatf("%s.err_count", nm), err_cnt - e0, exp_err);
    chk($sformatf("%s.kstrk", nm), int'(bus.kstrk), exp_ks);
    if (exp_kr > 0 && kr_cnt != kr0)
      chk_rng($sformatf("%s.kr_latency", nm), last_kr_cyc - last_fall_cyc, KR_LO, KR_HI);
    if (exp_err > 0 && err_cnt != e0)
      chk_rng($sformatf("%s.err_latency", nm), last_err_cyc - last_fall_cyc, ERR_LO, ERR_HI);
  endtask

  vec_t tbl[14];

  initial begin
    int kr0, e0, fall, ks_model;
    ev_kind_t k;
    logic [7:0] c;
    int ekr;

    tbl[0]  = '{EV_MAKE,        8'h1C, 0, 0,  0, 0};
    tbl[1]  = '{EV_REL,         8'h1C, 1, 1,  0, 0};
    tbl[2]  = '{EV_MAKE,        8'h1C, 0, 1,  0, 0};
    tbl[3]  = '{EV_MAKE,        8'h1C, 0, 1,  0, 0};
    tbl[4]  = '{EV_MAKE,        8'h1C, 0, 1,  0, 0};
    tbl[5]  = '{EV_REL,         8'h1A, 1, 26, 0, 500};
    tbl[6]  = '{EV_EXT_REL,     8'h1C, 0, 26, 0, 0};
    tbl[7]  = '{EV_REL,         8'h12, 0, 26, 0, 0};
    tbl[8]  = '{EV_REL_BADPAR,  8'h1C, 0, 26, 1, 0};
    tbl[9]  = '{EV_MAKE,        8'h1C, 0, 26, 0, 0};
    tbl[10] = '{EV_REL_BADSTOP, 8'h43, 0, 26, 1, 0};
    tbl[11] = '{EV_EXT_MAKE,    8'h75, 0, 26, 0, 0};
    tbl[12] = '{EV_REL,         8'h2C, 1, 20, 0, 0};
    tbl[13] = '{EV_REL,         8'h15, 1, 17, 0, 0};

    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset.kstrk", int'(bus.kstrk), 0);
    chk("reset.kr", int'(bus.kr), 0);
    chk("reset.frame_err", int'(bus.frame_err), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      apply_event(tbl[i].kind, tbl[i].code, tbl[i].exp_kr, tbl[i].exp_ks, tbl[i].exp_err,
                  $sformatf("tbl%0d", i));
      if (tbl[i].hold > 0) begin
        kr0 = kr_cnt;
        repeat (tbl[i].hold) @(negedge clk);
        chk($sformatf("tbl%0d.hold_kstrk", i), int'(bus.kstrk), tbl[i].exp_ks);
        chk($sformatf("tbl%0d.hold_kr", i), kr_cnt - kr0, 0);
      end
    end

    // Partial frame abandoned by the timeout.
    kr0 = kr_cnt;
    e0  = err_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 5);
    fall = last_fall_cyc;
    repeat (TOUT + 100) @(negedge clk);
    chk("timeout.err_count", err_cnt - e0, 1);
    chk("timeout.kr_count", kr_cnt - kr0, 0);
    chk_rng("timeout.err_cycle", last_err_cyc - fall, TOUT + SYNC + FLEN - 2, TOUT + SYNC + FLEN + 4);
    apply_event(EV_REL, 8'h2C, 1, 20, 0, "after_timeout");

    // Short low glitch on the idle clock line.
    kr0 = kr_cnt;
    e0  = err_cnt;
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch.err_count", err_cnt - e0, 0);
    chk("glitch.kr_count", kr_cnt - kr0, 0);
    apply_event(EV_REL, 8'h32, 1, 2, 0, "after_glitch");

    // Reset in the middle of a break-code frame.
    kr0 = kr_cnt;
    e0  = err_cnt;
    send_frame(8'hF0, 1'b0, 1'b0, 4);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.kstrk", int'(bus.kstrk), 0);
    chk("midreset.kr", int'(bus.kr), 0);
    chk("midreset.frame_err", int'(bus.frame_err), 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("midreset.kr_count", kr_cnt - kr0, 0);
    chk("midreset.err_count", err_cnt - e0, 0);
    apply_event(EV_REL, 8'h24, 1, 5, 0, "after_reset");

    // Random keystroke events against the event-level model.
    ks_model = 5;
    for (int r = 0; r < 15; r++) begin
      k = ev_kind_t'($urandom_range(0, 4));
      if ($urandom_range(0, 2) != 0) begin
        c = letter_sc[$urandom_range(0, 25)];
      end else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'hE0 || c == 8'hF0) c = 8'h12;
      end
      ekr = (k == EV_REL && ref_letter(c) != 0) ? 1 : 0;
      if (ekr != 0) ks_model = ref_letter(c);
      apply_event(k, c, ekr, ks_model, (k == EV_BAD) ? 1 : 0, $sformatf("rnd%0d", r));
    end

    chk("kr_and_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
